alu_lockstep_checker: RTL and testbench
=======================================

Name: alu_lockstep_checker

Overview:
Parametrised dual-channel lockstep ALU with registered pipeline and fault supervision. Two ALU channels run independent operand/op-select sets. Their results and carries are XOR-compared, and mismatches are counted. A three-state fault monitor escalates to a sticky FAULT once a programmable threshold is reached. It sits in the user project area behind the IO/LA tri-state wrapper, replacing the fixed 4-bit unregistered dual-ALU comparator.

Parameters:
WIDTH, 8, operand/result width per channel (>=2)
SEL_W, 2, op-select width (fixed encoding below; must be 2)
CNT_W, 8, mismatch counter width (saturating)

Ports:
wb_clk_i  input  1  clock, all state on rising edge
wb_rst_i  input  1  reset, asynchronous, active-high
in_valid  input  1  operand set valid this cycle
a0  input  WIDTH  channel 0 operand A
b0  input  WIDTH  channel 0 operand B
sel0  input  SEL_W  channel 0 op select
a1  input  WIDTH  channel 1 operand A
b1  input  WIDTH  channel 1 operand B
sel1  input  SEL_W  channel 1 op select
threshold  input  CNT_W  mismatch count that triggers FAULT; 0 disables FAULT
clear  input  1  synchronous clear of counter, state and sticky flags
out_valid  output  1  result/compare outputs valid
alu_out0  output  WIDTH  channel 0 result
carry0  output  1  channel 0 carry/borrow
alu_out1  output  WIDTH  channel 1 result
carry1  output  1  channel 1 carry/borrow
diff  output  WIDTH  alu_out0 ^ alu_out1
carry_diff  output  1  carry0 ^ carry1
mismatch  output  1  |diff | carry_diff, qualified by out_valid
err_cnt  output  CNT_W  saturating mismatch count
state  output  2  00 OK, 01 DEGRADED, 10 FAULT
fault  output  1  state == FAULT

Behaviour:
- Reset: all outputs 0, state OK, pipeline valids 0.
- Stage 1: on in_valid=1, capture a*/b*/sel* and set v1=1. Otherwise v1=0 and operand regs hold.
- Stage 2: from stage-1 regs, compute both ALUs, diff, carry_diff and mismatch. Register all of them plus out_valid=v1.
- Latency: 2 cycles, in_valid at edge N gives out_valid high after edge N+2. Full throughput, one operand set per cycle, no backpressure.
- Outputs hold their last values when out_valid=0. mismatch is forced 0 when out_valid=0.
- ALU encoding, per channel:
  - 00 ADD: {carry,out} = A+B, WIDTH+1 bits.
  - 01 SUB: out = A-B mod 2^WIDTH; carry = borrow (A<B unsigned).
  - 10 AND: carry 0.
  - 11 XOR: carry 0.
- err_cnt increments by 1 on each cycle where out_valid & mismatch. It saturates at 2^CNT_W-1 with no wrap.
- State machine, evaluated on the post-increment count:
  - OK -> DEGRADED when the count becomes >=1 and (threshold==0 or count < threshold).
  - OK/DEGRADED -> FAULT when threshold!=0 and count >= threshold. This includes a jump straight from OK when threshold==1.
  - FAULT is sticky; it is left only by clear or reset.
  - A threshold change while in DEGRADED is re-evaluated on the next mismatch only.
- clear=1: err_cnt=0, state=OK next edge. Clear takes priority over a simultaneous mismatch, so that mismatch is not counted. Pipeline data is unaffected.
- Reset asserted mid-stream: in-flight operand sets are discarded, out_valid=0 asynchronously. The first post-reset result appears 2 cycles after the first in_valid.

Decomposition:
- Package alu_lockstep_pkg holds:
  - op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_XOR=2'b11;
  - state constants ST_OK=2'b00, ST_DEGRADED=2'b01, ST_FAULT=2'b10.
- One sub-module, alu_core (parameter WIDTH): purely combinational, ports a, b, sel, out, carry. It is instantiated twice, one per channel.
- Counter and state machine stay in the top module.

Test Plan:
- ADD with carry: WIDTH=8, both channels a=8'hF0, b=8'h20, sel=00, in_valid one cycle.
  -> 2 cycles later out_valid=1, alu_out0=alu_out1=8'h10, carry0=carry1=1, diff=0, mismatch=0, err_cnt=0, state OK.
- SUB borrow plus single mismatch: ch0 a=5, b=7, sel=01; ch1 a=5, b=6, sel=01; threshold=3.
  -> alu_out0=8'hFE, carry0=1, alu_out1=8'hFF, carry1=1, diff=8'h01, carry_diff=0, mismatch=1, err_cnt=1, state DEGRADED.
- Threshold escalation: threshold=3, three consecutive mismatching sets, then matching sets.
  -> err_cnt 1,2,3 on consecutive cycles; state goes DEGRADED, DEGRADED, FAULT; fault=1 stays high through later matching results.
- Saturation and disable: threshold=0, CNT_W=8, 300 mismatching back-to-back sets.
  -> err_cnt stops at 8'hFF, state stays DEGRADED, fault=0.
- Clear priority: clear=1 on the same cycle as a mismatching out_valid, err_cnt=2 beforehand.
  -> next cycle err_cnt=0, state OK; the following mismatch gives err_cnt=1.
- Async reset mid-stream: in_valid on 2 consecutive cycles, assert wb_rst_i between edges right after the second.
  -> out_valid drops immediately, all outputs 0, err_cnt=0, no result emitted for either set after release.

Source files
------------

// File: rtl/alu_lockstep_checker_pkg.sv
// Shared op-select and supervision-state encodings for the lockstep ALU checker.
package alu_lockstep_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_FAULT    = 2'b10
  } state_e;

endpackage

// File: rtl/alu_lockstep_checker_if.sv
// Operand/result bundle of the lockstep checker; master drives operands, slave is the checker.
interface alu_lockstep_checker_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [SEL_W-1:0] sel0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [SEL_W-1:0] sel1;
  logic [CNT_W-1:0] threshold;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] alu_out0;
  logic             carry0;
  logic [WIDTH-1:0] alu_out1;
  logic             carry1;
  logic [WIDTH-1:0] diff;
  logic             carry_diff;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic [1:0]       state;
  logic             fault;

  modport master (
    output in_valid, a0, b0, sel0, a1, b1, sel1, threshold, clear,
    input  out_valid, alu_out0, carry0, alu_out1, carry1, diff, carry_diff,
           mismatch, err_cnt, state, fault
  );

  modport slave (
    input  in_valid, a0, b0, sel0, a1, b1, sel1, threshold, clear,
    output out_valid, alu_out0, carry0, alu_out1, carry1, diff, carry_diff,
           mismatch, err_cnt, state, fault
  );
endinterface

// File: rtl/alu_lockstep_checker_alu_core.sv
// One combinational ALU channel: ADD/SUB with carry/borrow, AND, XOR.
module alu_core
  import alu_lockstep_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic             carry
);

  always_comb begin
    out   = '0;
    carry = 1'b0;
    case (sel)
      OP_ADD:  {carry, out} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        out   = a - b;
        carry = (a < b);
      end
      OP_AND:  out = a & b;
      OP_XOR:  out = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_lockstep_checker.sv
// Two-stage dual-channel lockstep ALU with XOR compare, saturating mismatch
// counter and a sticky OK/DEGRADED/FAULT supervisor.
module alu_lockstep_checker
  import alu_lockstep_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  alu_lockstep_checker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             r_v1;
  logic [WIDTH-1:0] r_a0, r_b0, r_a1, r_b1;
  logic [SEL_W-1:0] r_sel0, r_sel1;

  logic [WIDTH-1:0] w_out0, w_out1, w_diff;
  logic             w_c0, w_c1, w_cdiff, w_mis;

  logic             r_ov, r_c0, r_c1, r_cdiff, r_mis, r_fault;
  logic [WIDTH-1:0] r_out0, r_out1, r_diff;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  state_e           r_state, w_state_next;

  // Stage 1: operand capture; regs hold while idle
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_v1   <= 1'b0;
      r_a0   <= '0;
      r_b0   <= '0;
      r_sel0 <= '0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sel1 <= '0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) begin
        r_a0   <= bus.a0;
        r_b0   <= bus.b0;
        r_sel0 <= bus.sel0;
        r_a1   <= bus.a1;
        r_b1   <= bus.b1;
        r_sel1 <= bus.sel1;
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_alu0 (.a(r_a0), .b(r_b0), .sel(r_sel0), .out(w_out0), .carry(w_c0));
  alu_core #(.WIDTH(WIDTH)) u_alu1 (.a(r_a1), .b(r_b1), .sel(r_sel1), .out(w_out1), .carry(w_c1));

  assign w_diff  = w_out0 ^ w_out1;
  assign w_cdiff = w_c0 ^ w_c1;
  assign w_mis   = r_v1 & ((|w_diff) | w_cdiff);

  // Stage 2: results hold their last value when no new set arrives
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ov    <= 1'b0;
      r_mis   <= 1'b0;
      r_out0  <= '0;
      r_c0    <= 1'b0;
      r_out1  <= '0;
      r_c1    <= 1'b0;
      r_diff  <= '0;
      r_cdiff <= 1'b0;
    end else begin
      r_ov  <= r_v1;
      r_mis <= w_mis;
      if (r_v1) begin
        r_out0  <= w_out0;
        r_c0    <= w_c0;
        r_out1  <= w_out1;
        r_c1    <= w_c1;
        r_diff  <= w_diff;
        r_cdiff <= w_cdiff;
      end
    end
  end

  // Supervisor next state; the counter advances with the mismatch it reports
  always_comb begin
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    if (bus.clear) begin
      w_cnt_next   = '0;
      w_state_next = ST_OK;
    end else if (w_mis) begin
      if (r_cnt != CNT_MAX) w_cnt_next = r_cnt + CNT_W'(1);
      if (r_state != ST_FAULT) begin
        if ((bus.threshold != '0) && (w_cnt_next >= bus.threshold)) w_state_next = ST_FAULT;
        else                                                         w_state_next = ST_DEGRADED;
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt   <= '0;
      r_state <= ST_OK;
      r_fault <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
      r_fault <= (w_state_next == ST_FAULT);
    end
  end

  assign bus.out_valid  = r_ov;
  assign bus.alu_out0   = r_out0;
  assign bus.carry0     = r_c0;
  assign bus.alu_out1   = r_out1;
  assign bus.carry1     = r_c1;
  assign bus.diff       = r_diff;
  assign bus.carry_diff = r_cdiff;
  assign bus.mismatch   = r_mis;
  assign bus.err_cnt    = r_cnt;
  assign bus.state      = r_state;
  assign bus.fault      = r_fault;

endmodule

// File: tb/tb_alu_lockstep_checker.sv
// Directed and randomized checks of alu_lockstep_checker against an arithmetic reference model.
module tb_alu_lockstep_checker;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 8;
  localparam int MODW    = 256;
  localparam int CNT_MAX = 255;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_lockstep_checker_if #(.WIDTH(WIDTH), .SEL_W(2), .CNT_W(CNT_W)) bus ();

  alu_lockstep_checker #(.WIDTH(WIDTH), .SEL_W(2), .CNT_W(CNT_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit v;
    int a0, b0, s0, a1, b1, s1;
  } opset_t;

  opset_t m_s1;
  bit     m_ov, m_mis, m_c0, m_c1;
  int     m_o0, m_o1, m_cnt, m_st;

  function automatic void ref_alu(input int a, input int b, input int op,
                                  output int res, output bit c);
    c = 1'b0;
    case (op)
      0: begin res = (a + b) % MODW; c = ((a + b) >= MODW); end
      1: begin res = (a - b + MODW) % MODW; c = (a < b); end
      2: res = a & b;
      default: res = a ^ b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = '{v: 1'b0, a0: 0, b0: 0, s0: 0, a1: 0, b1: 0, s1: 0};
    m_ov = 0; m_mis = 0; m_c0 = 0; m_c1 = 0; m_o0 = 0; m_o1 = 0;
    m_cnt = 0; m_st = 0;
  endtask

  // Advance the model by one clock edge using the inputs presented before it
  task automatic model_edge();
    bit mis;
    mis = 1'b0;
    if (m_s1.v) begin
      ref_alu(m_s1.a0, m_s1.b0, m_s1.s0, m_o0, m_c0);
      ref_alu(m_s1.a1, m_s1.b1, m_s1.s1, m_o1, m_c1);
      mis = (m_o0 != m_o1) || (m_c0 != m_c1);
    end
    m_ov  = m_s1.v;
    m_mis = mis;
    if (bus.clear) begin
      m_cnt = 0;
      m_st  = 0;
    end else if (mis) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (m_st != 2) m_st = (int'(bus.threshold) != 0 && m_cnt >= int'(bus.threshold)) ? 2 : 1;
    end
    m_s1.v = bus.in_valid;
    if (bus.in_valid) begin
      m_s1.a0 = int'(bus.a0); m_s1.b0 = int'(bus.b0); m_s1.s0 = int'(bus.sel0);
      m_s1.a1 = int'(bus.a1); m_s1.b1 = int'(bus.b1); m_s1.s1 = int'(bus.sel1);
    end
  endtask

  task automatic check_all();
    chk("out_valid",  32'(bus.out_valid),  32'(m_ov));
    chk("alu_out0",   32'(bus.alu_out0),   32'(m_o0));
    chk("carry0",     32'(bus.carry0),     32'(m_c0));
    chk("alu_out1",   32'(bus.alu_out1),   32'(m_o1));
    chk("carry1",     32'(bus.carry1),     32'(m_c1));
    chk("diff",       32'(bus.diff),       32'(m_o0 ^ m_o1));
    chk("carry_diff", 32'(bus.carry_diff), 32'(m_c0 ^ m_c1));
    chk("mismatch",   32'(bus.mismatch),   32'(m_mis));
    chk("err_cnt",    32'(bus.err_cnt),    32'(m_cnt));
    chk("state",      32'(bus.state),      32'(m_st));
    chk("fault",      32'(bus.fault),      32'(m_st == 2));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input bit v, input int a0, input int b0, input int s0,
                        input int a1, input int b1, input int s1);
    bus.in_valid = v;
    bus.a0 = 8'(a0); bus.b0 = 8'(b0); bus.sel0 = 2'(s0);
    bus.a1 = 8'(a1); bus.b1 = 8'(b1); bus.sel1 = 2'(s1);
  endtask

  task automatic do_clear();
    set_in(0, 0, 0, 0, 0, 0, 0);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.clear = 1'b0;
    bus.threshold = '0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    chk("reset_state", 32'(bus.state), 32'd0);
    @(negedge clk) rst = 1'b0;

    // ADD with carry on both channels
    bus.threshold = 8'd3;
    set_in(1, 'hF0, 'h20, 0, 'hF0, 'h20, 0);
    cyc();
    chk("add_lat_ov0", 32'(bus.out_valid), 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("add_out0", 32'(bus.alu_out0), 32'h10);
    chk("add_c0",   32'(bus.carry0),   32'd1);
    chk("add_mis",  32'(bus.mismatch), 32'd0);
    cyc();
    chk("hold_ov0",  32'(bus.out_valid), 32'd0);
    chk("hold_out0", 32'(bus.alu_out0),  32'h10);

    // SUB borrow with a single channel disagreement
    set_in(1, 5, 7, 1, 5, 6, 1);
    cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("sub_out0", 32'(bus.alu_out0), 32'hFE);
    chk("sub_out1", 32'(bus.alu_out1), 32'hFF);
    chk("sub_diff", 32'(bus.diff),     32'h01);
    chk("sub_cnt",  32'(bus.err_cnt),  32'd1);
    chk("sub_st",   32'(bus.state),    32'd1);

    // Escalation to sticky FAULT at threshold 3
    do_clear();
    for (int i = 0; i < 8; i++) begin
      if (i < 3)      set_in(1, 5, 7, 1, 5, 6, 1);
      else if (i < 6) set_in(1, 9, 3, 0, 9, 3, 0);
      else            set_in(0, 0, 0, 0, 0, 0, 0);
      cyc();
      if (i >= 1 && i <= 3) begin
        chk("esc_cnt", 32'(bus.err_cnt), 32'(i));
        chk("esc_st",  32'(bus.state),   (i == 3) ? 32'd2 : 32'd1);
      end
    end
    chk("esc_fault_sticky", 32'(bus.fault), 32'd1);

    // Saturation with FAULT disabled
    do_clear();
    bus.threshold = '0;
    for (int i = 0; i < 300; i++) begin
      set_in(1, 5, 7, 1, 5, 6, 1);
      cyc();
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("sat_cnt",   32'(bus.err_cnt), 32'hFF);
    chk("sat_st",    32'(bus.state),   32'd1);
    chk("sat_fault", 32'(bus.fault),   32'd0);

    // Clear wins over a coincident mismatch
    do_clear();
    set_in(1, 5, 7, 1, 5, 6, 1); cyc();
    set_in(1, 5, 7, 1, 5, 6, 1); cyc();
    set_in(1, 5, 7, 1, 5, 6, 1); cyc();
    chk("clr_pre_cnt", 32'(bus.err_cnt), 32'd2);
    set_in(0, 0, 0, 0, 0, 0, 0);
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
    chk("clr_cnt", 32'(bus.err_cnt),  32'd0);
    chk("clr_st",  32'(bus.state),    32'd0);
    chk("clr_mis", 32'(bus.mismatch), 32'd1);
    set_in(1, 5, 7, 1, 5, 6, 1); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("clr_next_cnt", 32'(bus.err_cnt), 32'd1);

    // Randomized traffic with occasional threshold changes and clears
    for (int i = 0; i < 400; i++) begin
      int a, b, s;
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) set_in($urandom_range(0, 3) != 0, a, b, s, a, b, s);
      else set_in($urandom_range(0, 3) != 0, a, b, s,
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 15) == 0) bus.threshold = 8'($urandom_range(0, 8));
      bus.clear = ($urandom_range(0, 31) == 0);
      cyc();
    end
    bus.clear = 1'b0;

    // Asynchronous reset with two sets in flight
    do_clear();
    bus.threshold = 8'd3;
    set_in(1, 5, 7, 1, 5, 6, 1); cyc();
    set_in(1, 1, 2, 0, 1, 2, 0); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_ov_async", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_no_result", 32'(bus.out_valid), 32'd0);
    end
    set_in(1, 3, 4, 3, 3, 4, 3); cyc();
    set_in(0, 0, 0, 0, 0, 0, 0); cyc();
    chk("rst_first_ov",  32'(bus.out_valid), 32'd1);
    chk("rst_first_out", 32'(bus.alu_out0),  32'd7);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
